// File: rtl/axi_stream_fifo_buffer_if.sv
// AXI4-Stream link bundle used on both sides of axi_stream_fifo_buffer.
//  master modport: drives payload + tvalid, receives tready
//  slave  modport: receives payload + tvalid, drives tready
//  Fields: tdata[DATA_WIDTH], tstrb/tkeep[DATA_WIDTH/8], tuser[USER_WIDTH],
//          tdest[DEST_WIDTH], tid[ID_WIDTH], tlast, tvalid, tready
interface axi_stream_fifo_buffer_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned USER_WIDTH = 1,
   parameter int unsigned DEST_WIDTH = 1,
   parameter int unsigned ID_WIDTH   = 1
);
   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tstrb;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic [USER_WIDTH-1:0] tuser;
   logic [DEST_WIDTH-1:0] tdest;
   logic [ID_WIDTH-1:0]   tid;
   logic                  tlast;
   logic                  tvalid;
   logic                  tready;

   modport master (
      output tdata, tstrb, tkeep, tuser, tdest, tid, tlast, tvalid,
      input  tready
   );

   modport slave (
      input  tdata, tstrb, tkeep, tuser, tdest, tid, tlast, tvalid,
      output tready
   );
endinterface

// File: rtl/axi_stream_fifo_buffer.sv
// Elastic AXI4-Stream FIFO with a registered first-word-fall-through head stage.
// Ports:
//  clk, rst_n  single rising-edge clock, asynchronous active-low reset
//  s_axis      slave stream in (s_axis.tready is registered)
//  m_axis      master stream out (all fields registered)
//  level       entries currently stored, 0..DEPTH
//  pkt_count   complete packets stored (only with AXIS_FIFO_PACKET_MODE_EN)
// Build option AXIS_FIFO_PACKET_MODE_EN: store-and-forward; the head is released only
// once a whole packet is stored or the buffer is full. Undefined: cut-through.
module axi_stream_fifo_buffer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned USER_WIDTH = 1,
   parameter int unsigned DEST_WIDTH = 1,
   parameter int unsigned ID_WIDTH   = 1,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   axi_stream_fifo_buffer_if.slave     s_axis,
   axi_stream_fifo_buffer_if.master    m_axis,
`ifdef AXIS_FIFO_PACKET_MODE_EN
   output logic [$clog2(DEPTH):0]      pkt_count,
`endif
   output logic [$clog2(DEPTH):0]      level
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned KW = DATA_WIDTH / 8;
   localparam int unsigned PW = DATA_WIDTH + 2 * KW + USER_WIDTH + DEST_WIDTH + ID_WIDTH + 1;

   logic [PW-1:0] mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] wr_payload;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   avail;
   logic          m_tvalid_q, m_tvalid_d;
   logic          s_tready_q, s_tready_d;
   logic          head_ok;
   logic          push_c;
   logic          pop_c;

`ifdef AXIS_FIFO_PACKET_MODE_EN
   logic [AW:0]   pkts_q, pkts_d;
   logic [AW:0]   pkts_after_pop;
   logic          head_last;
`endif

   // tlast sits in the LSB so the packet logic can find it in the head stage
   assign wr_payload = {s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tuser,
                        s_axis.tdest, s_axis.tid, s_axis.tlast};

   assign push_c = s_axis.tvalid && s_tready_q;
   assign pop_c  = m_tvalid_q && m_axis.tready;

   // Pointer, occupancy and head-stage next-state
   always_comb begin
      wr_ptr_d   = wr_ptr_q + AW'(push_c);
      rd_ptr_d   = rd_ptr_q + AW'(pop_c);
      count_d    = count_q + (AW+1)'(push_c) - (AW+1)'(pop_c);
      s_tready_d = count_d < (AW+1)'(DEPTH);
      // Only entries written on earlier edges may reach the head: no same-cycle bypass
      avail      = count_q - (AW+1)'(pop_c);
`ifdef AXIS_FIFO_PACKET_MODE_EN
      head_last      = head_q[0];
      pkts_d         = pkts_q + (AW+1)'(push_c && s_axis.tlast)
                              - (AW+1)'(pop_c && head_last);
      pkts_after_pop = pkts_q - (AW+1)'(pop_c && head_last);
      // Full buffer overrides the packet gate so oversize packets cannot deadlock
      head_ok        = (avail != '0) &&
                       ((pkts_after_pop != '0) || (count_q == (AW+1)'(DEPTH)));
`else
      head_ok        = (avail != '0);
`endif
      m_tvalid_d = head_ok;
      head_d     = head_q;
      if (head_ok) begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // Control and head-stage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         m_tvalid_q <= 1'b0;
         s_tready_q <= 1'b0;
         head_q     <= '0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
         pkts_q     <= '0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         m_tvalid_q <= m_tvalid_d;
         s_tready_q <= s_tready_d;
         head_q     <= head_d;
`ifdef AXIS_FIFO_PACKET_MODE_EN
         pkts_q     <= pkts_d;
`endif
      end
   end

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= wr_payload;
      end
   end

   assign s_axis.tready = s_tready_q;
   assign m_axis.tvalid = m_tvalid_q;
   assign {m_axis.tdata, m_axis.tstrb, m_axis.tkeep, m_axis.tuser,
           m_axis.tdest, m_axis.tid, m_axis.tlast} = head_q;
   assign level = count_q;
`ifdef AXIS_FIFO_PACKET_MODE_EN
   assign pkt_count = pkts_q;
`endif
endmodule
